// File: rtl/axis_byte_packer_if.sv
// AXI-Stream source bundle driven by axis_byte_packer.
// The master side produces packed words; the slave side applies back-pressure.
interface axis_byte_packer_if #(
  parameter int LOGIC_SIZE = 32
);
  localparam int LANES = LOGIC_SIZE / 8;

  logic [LOGIC_SIZE-1:0] s_axis_tdata;
  logic [LANES-1:0]      s_axis_tkeep;
  logic                  s_axis_tlast;
  logic                  s_axis_valid;
  logic                  s_axis_ready;

  modport master (
    output s_axis_tdata,
    output s_axis_tkeep,
    output s_axis_tlast,
    output s_axis_valid,
    input  s_axis_ready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tkeep,
    input  s_axis_tlast,
    input  s_axis_valid,
    output s_axis_ready
  );
endinterface

// File: rtl/axis_byte_packer.sv
// Byte-to-word packer: drains a first-word-fall-through byte FIFO and
// presents packed LOGIC_SIZE-bit words on an AXI-Stream source through a
// small circular output buffer of OUT_DEPTH entries.
// Optional packet framing is enabled with the macro AXIS_PACK_TLAST_EN:
// i_last then closes the current word early with a partial tkeep and tlast=1.
// Without it, i_last is ignored, words always hold LANES bytes and tlast is 0.
module axis_byte_packer #(
  parameter int LOGIC_SIZE = 32,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                       s_axis_aclk,
  input  logic                       s_axis_reset,
  input  logic [7:0]                 i_from_fifo,
  input  logic                       i_last,
  input  logic                       r_empty,
  output logic                       r_req,
  output logic [$clog2(OUT_DEPTH):0] o_level,
  axis_byte_packer_if.master         axis
);
  localparam int LANES  = LOGIC_SIZE / 8;
  localparam int LANE_W = $clog2(LANES);
  localparam int IDX_W  = $clog2(OUT_DEPTH);
  localparam int PTR_W  = IDX_W + 1;

  logic [LANE_W-1:0]     lane;
  logic [LOGIC_SIZE-1:0] asm_data;
  logic [LOGIC_SIZE-1:0] word_next;
  logic                  completes;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  valid;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [LOGIC_SIZE-1:0] mem_data [OUT_DEPTH];

`ifdef AXIS_PACK_TLAST_EN
  logic [LANES-1:0] keep_reg;
  logic [LANES-1:0] keep_next;
  logic [LANES-1:0] mem_keep [OUT_DEPTH];
  logic             mem_last [OUT_DEPTH];

  assign completes = (lane == LANE_W'(LANES - 1)) || i_last;
  assign keep_next = keep_reg | (LANES'(1) << lane);
`else
  logic unused_last;

  assign unused_last = i_last;
  assign completes   = (lane == LANE_W'(LANES - 1));
`endif

  assign wr_idx  = wr_ptr[PTR_W-2:0];
  assign rd_idx  = rd_ptr[PTR_W-2:0];
  assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  assign o_level = wr_ptr - rd_ptr;
  assign valid   = (o_level != '0);

  // A completing byte is only taken when a buffer slot is free; ready is
  // deliberately not part of this so a same-cycle pop never frees a slot.
  assign r_req = !s_axis_reset && !r_empty && (!completes || !full);
  assign push  = r_req && completes;
  assign pop   = valid && axis.s_axis_ready;

  assign axis.s_axis_valid = valid;
  assign axis.s_axis_tdata = valid ? mem_data[rd_idx] : '0;
`ifdef AXIS_PACK_TLAST_EN
  assign axis.s_axis_tkeep = valid ? mem_keep[rd_idx] : '0;
  assign axis.s_axis_tlast = valid && mem_last[rd_idx];
`else
  assign axis.s_axis_tkeep = {LANES{valid}};
  assign axis.s_axis_tlast = 1'b0;
`endif

  // Merge the incoming byte into its lane of the partial word.
  always_comb begin
    word_next = asm_data;
    word_next[int'(lane)*8 +: 8] = i_from_fifo;
  end

  // Assembly register and lane pointer; cleared whenever a word is pushed.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_reset) begin
      lane     <= '0;
      asm_data <= '0;
`ifdef AXIS_PACK_TLAST_EN
      keep_reg <= '0;
`endif
    end else if (r_req) begin
      if (completes) begin
        lane     <= '0;
        asm_data <= '0;
`ifdef AXIS_PACK_TLAST_EN
        keep_reg <= '0;
`endif
      end else begin
        lane     <= lane + 1'b1;
        asm_data <= word_next;
`ifdef AXIS_PACK_TLAST_EN
        keep_reg <= keep_next;
`endif
      end
    end
  end

  // Circular buffer pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Buffer storage; contents need no reset because valid gates the outputs.
  always_ff @(posedge s_axis_aclk) begin
    if (push) begin
      mem_data[wr_idx] <= word_next;
`ifdef AXIS_PACK_TLAST_EN
      mem_keep[wr_idx] <= keep_next;
      mem_last[wr_idx] <= i_last;
`endif
    end
  end
endmodule

// File: tb/tb_axis_byte_packer.sv
// Self-checking bench for axis_byte_packer: a 32-bit/depth-4 instance driven
// with directed byte sequences, and a 64-bit/depth-2 instance driven with
// random FIFO gaps and random back-pressure against a byte-order scoreboard.
module tb_axis_byte_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // 32-bit instance
  logic [7:0]  a_byte  = 8'h00;
  logic        a_last  = 1'b0;
  logic        a_empty = 1'b1;
  logic        a_req;
  logic [2:0]  a_level;
  logic [8:0]  a_src [$];
  logic [36:0] a_out [$];
  int          a_max_level = 0;
  logic        a_stall = 1'b0;
  logic [36:0] a_prev  = '0;

  axis_byte_packer_if #(.LOGIC_SIZE(32)) a_if ();

  axis_byte_packer #(.LOGIC_SIZE(32), .OUT_DEPTH(4)) dut_a (
    .s_axis_aclk (clk),
    .s_axis_reset(rst),
    .i_from_fifo (a_byte),
    .i_last      (a_last),
    .r_empty     (a_empty),
    .r_req       (a_req),
    .o_level     (a_level),
    .axis        (a_if)
  );

  // 64-bit instance
  logic [7:0]  b_byte  = 8'h00;
  logic        b_empty = 1'b1;
  logic        b_req;
  logic [1:0]  b_level;
  logic [7:0]  b_src [$];
  logic [7:0]  b_exp [$];
  logic [72:0] b_out [$];
  bit          b_run   = 1'b0;
  logic        b_stall = 1'b0;
  logic [72:0] b_prev  = '0;

  axis_byte_packer_if #(.LOGIC_SIZE(64)) b_if ();

  axis_byte_packer #(.LOGIC_SIZE(64), .OUT_DEPTH(2)) dut_b (
    .s_axis_aclk (clk),
    .s_axis_reset(rst),
    .i_from_fifo (b_byte),
    .i_last      (1'b0),
    .r_empty     (b_empty),
    .r_req       (b_req),
    .o_level     (b_level),
    .axis        (b_if)
  );

  logic [7:0]  v;
  logic [63:0] exp_b;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Queue one byte (with its packet-end flag) into the model upstream FIFO.
  task automatic applyStimulus(input logic [7:0] b, input logic last);
    a_src.push_back({last, b});
  endtask

  task automatic tick();
    @(negedge clk);
    #4;
  endtask

  task automatic setReady(input logic r);
    @(negedge clk);
    #1;
    a_if.s_axis_ready = r;
    #3;
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] base);
    return {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endfunction

  // Upstream FIFO model and output monitor for the 32-bit instance.
  always begin
    @(negedge clk);
    a_empty = (a_src.size() == 0);
    {a_last, a_byte} = (a_src.size() != 0) ? a_src[0] : 9'h000;
    #3;
    if (a_stall) begin
      checkOutput("a_hold_valid", a_if.s_axis_valid, 1);
      checkOutput("a_hold_beat", {a_if.s_axis_tlast, a_if.s_axis_tkeep, a_if.s_axis_tdata}, a_prev);
    end
    if (a_req === 1'b1) begin
      if (a_empty) checkOutput("a_req_while_empty", a_req, 0);
      else void'(a_src.pop_front());
    end
    if (a_if.s_axis_valid && a_if.s_axis_ready)
      a_out.push_back({a_if.s_axis_tlast, a_if.s_axis_tkeep, a_if.s_axis_tdata});
    if (a_level > 3'(a_max_level)) a_max_level = int'(a_level);
    a_stall = a_if.s_axis_valid && !a_if.s_axis_ready && !rst;
    a_prev  = {a_if.s_axis_tlast, a_if.s_axis_tkeep, a_if.s_axis_tdata};
  end

  // Random-gap FIFO model, random back-pressure and monitor for the 64-bit instance.
  always begin
    @(negedge clk);
    if (b_run) begin
      b_empty = !((b_src.size() != 0) && ($urandom_range(0, 3) != 0));
      b_if.s_axis_ready = ($urandom_range(0, 2) != 0);
    end else begin
      b_empty = 1'b1;
      b_if.s_axis_ready = 1'b0;
    end
    b_byte = (b_src.size() != 0) ? b_src[0] : 8'h00;
    #3;
    if (b_stall) begin
      checkOutput("b_hold_valid", b_if.s_axis_valid, 1);
      checkOutput("b_hold_beat", b_if.s_axis_tdata, b_prev[63:0]);
    end
    if (b_req === 1'b1) begin
      if (b_empty) checkOutput("b_req_while_empty", b_req, 0);
      else void'(b_src.pop_front());
    end
    if (b_if.s_axis_valid && b_if.s_axis_ready)
      b_out.push_back({b_if.s_axis_tlast, b_if.s_axis_tkeep, b_if.s_axis_tdata});
    b_stall = b_if.s_axis_valid && !b_if.s_axis_ready && !rst;
    b_prev  = {b_if.s_axis_tlast, b_if.s_axis_tkeep, b_if.s_axis_tdata};
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, compared %0d", n_compared);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    a_if.s_axis_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_valid", a_if.s_axis_valid, 0);
    checkOutput("rst_level", a_level, 0);
    checkOutput("rst_req", a_req, 0);
    checkOutput("rst_tdata", a_if.s_axis_tdata, 0);
    checkOutput("rst_tkeep", a_if.s_axis_tkeep, 0);
    checkOutput("rst_tlast", a_if.s_axis_tlast, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    #3;
    setReady(1);

    // Single word, one beat, valid the cycle after the completing byte
    $display("[TB] basic packing");
    a_out.delete();
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b0);
    applyStimulus(8'h44, 1'b0);
    repeat (4) tick();
    checkOutput("t1_valid_before", a_if.s_axis_valid, 0);
    tick();
    checkOutput("t1_valid", a_if.s_axis_valid, 1);
    checkOutput("t1_tdata", a_if.s_axis_tdata, 32'h44332211);
    checkOutput("t1_tkeep", a_if.s_axis_tkeep, 4'hF);
    checkOutput("t1_tlast", a_if.s_axis_tlast, 0);
    checkOutput("t1_level", a_level, 1);
    tick();
    checkOutput("t1_valid_after", a_if.s_axis_valid, 0);
    checkOutput("t1_beats", a_out.size(), 1);

    // Back-pressure: fill the buffer, then drain
    $display("[TB] back-pressure");
    setReady(0);
    a_out.delete();
    for (int i = 0; i < 20; i++) applyStimulus(8'(8'h40 + i), 1'b0);
    repeat (25) tick();
    checkOutput("t2_level_full", a_level, 4);
    checkOutput("t2_req_held", a_req, 0);
    checkOutput("t2_bytes_left", a_src.size(), 1);
    checkOutput("t2_head_data", a_if.s_axis_tdata, 32'h43424140);
    setReady(1);
    checkOutput("t2_req_at_pop", a_req, 0);
    tick();
    checkOutput("t2_req_resume", a_req, 1);
    checkOutput("t2_level_after_pop", a_level, 3);
    for (int i = 0; i < 60 && a_out.size() < 5; i++) tick();
    checkOutput("t2_words", a_out.size(), 5);
    for (int w = 0; w < a_out.size() && w < 5; w++) begin
      checkOutput($sformatf("t2_word%0d", w), a_out[w][31:0], pack4(8'(8'h40 + 4 * w)));
      checkOutput($sformatf("t2_keep%0d", w), a_out[w][35:32], 4'hF);
    end

    // Concurrent push/pop from a full buffer, pointers wrap several times
    $display("[TB] concurrent push/pop");
    setReady(0);
    a_out.delete();
    for (int i = 0; i < 80; i++) applyStimulus(8'(8'h80 + i), 1'b0);
    repeat (25) tick();
    checkOutput("t3_level_full", a_level, 4);
    a_max_level = 0;
    setReady(1);
    for (int i = 0; i < 200 && a_out.size() < 20; i++) tick();
    repeat (3) tick();
    checkOutput("t3_words", a_out.size(), 20);
    checkOutput("t3_level_bound", (a_max_level <= 4), 1);
    checkOutput("t3_level_end", a_level, 0);
    for (int w = 0; w < a_out.size() && w < 20; w++)
      checkOutput($sformatf("t3_word%0d", w), a_out[w][31:0], pack4(8'(8'h80 + 4 * w)));

    // Packet framing through i_last
    $display("[TB] framing");
    a_out.delete();
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b1);
    applyStimulus(8'hCC, 1'b0);
    applyStimulus(8'hDD, 1'b0);
    applyStimulus(8'hEE, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b1);
    for (int i = 0; i < 40 && a_src.size() != 0; i++) tick();
    repeat (6) tick();
`ifdef AXIS_PACK_TLAST_EN
    checkOutput("t4_words", a_out.size(), 3);
    if (a_out.size() >= 3) begin
      checkOutput("t4_w0_data", a_out[0][31:0], 32'h0000BBAA);
      checkOutput("t4_w0_keep", a_out[0][35:32], 4'h3);
      checkOutput("t4_w0_last", a_out[0][36], 1);
      checkOutput("t4_w1_data", a_out[1][31:0], 32'hFFEEDDCC);
      checkOutput("t4_w1_keep", a_out[1][35:32], 4'hF);
      checkOutput("t4_w1_last", a_out[1][36], 0);
      checkOutput("t4_w2_data", a_out[2][31:0], 32'h00002211);
      checkOutput("t4_w2_keep", a_out[2][35:32], 4'h3);
      checkOutput("t4_w2_last", a_out[2][36], 1);
    end
`else
    checkOutput("t4_words", a_out.size(), 2);
    if (a_out.size() >= 2) begin
      checkOutput("t4_w0_data", a_out[0][31:0], 32'hDDCCBBAA);
      checkOutput("t4_w0_keep", a_out[0][35:32], 4'hF);
      checkOutput("t4_w0_last", a_out[0][36], 0);
      checkOutput("t4_w1_data", a_out[1][31:0], 32'h2211FFEE);
      checkOutput("t4_w1_keep", a_out[1][35:32], 4'hF);
      checkOutput("t4_w1_last", a_out[1][36], 0);
    end
`endif

    // Reset mid-word with buffered words
    $display("[TB] reset mid-transfer");
    setReady(0);
    a_out.delete();
    for (int i = 0; i < 10; i++) applyStimulus(8'(8'h50 + i), 1'b0);
    repeat (15) tick();
    checkOutput("t5_level_pre", a_level, 2);
    checkOutput("t5_src_drained", a_src.size(), 0);
    applyStimulus(8'h01, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #3;
    checkOutput("t5_req_gated", a_req, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    #3;
    checkOutput("t5_valid", a_if.s_axis_valid, 0);
    checkOutput("t5_level", a_level, 0);
    checkOutput("t5_tdata", a_if.s_axis_tdata, 0);
    checkOutput("t5_tkeep", a_if.s_axis_tkeep, 0);
    checkOutput("t5_req_after", a_req, 1);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h04, 1'b0);
    setReady(1);
    for (int i = 0; i < 40 && a_out.size() < 1; i++) tick();
    repeat (6) tick();
    checkOutput("t5_words", a_out.size(), 1);
    if (a_out.size() >= 1) begin
      checkOutput("t5_word", a_out[0][31:0], 32'h04030201);
      checkOutput("t5_keep", a_out[0][35:32], 4'hF);
    end

    // 64-bit lanes, depth 2, random gaps and back-pressure
    $display("[TB] random 64-bit stream");
    for (int i = 0; i < 80; i++) begin
      v = 8'($urandom_range(0, 255));
      b_src.push_back(v);
      b_exp.push_back(v);
    end
    b_run = 1'b1;
    for (int i = 0; i < 2000 && b_out.size() < 10; i++) tick();
    b_run = 1'b0;
    repeat (3) tick();
    checkOutput("b_words", b_out.size(), 10);
    for (int w = 0; w < b_out.size() && w < 10; w++) begin
      exp_b = '0;
      for (int k = 0; k < 8; k++) exp_b[k*8 +: 8] = b_exp[8 * w + k];
      checkOutput($sformatf("b_word%0d", w), b_out[w][63:0], exp_b);
      checkOutput($sformatf("b_keep%0d", w), b_out[w][71:64], 8'hFF);
      checkOutput($sformatf("b_last%0d", w), b_out[w][72], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
